// File: rtl/fl_ticket_distributor.sv
// FrameLink round-robin distributor: deals whole frames to OUTPUT_COUNT
// streams and stamps each frame with a sequence ticket for reordering.
module fl_ticket_distributor #(
    parameter int DATA_WIDTH    = 16,
    parameter int OUTPUT_COUNT  = 4,
    parameter int PARTS         = 3,
    parameter int TICKET_PART   = 0,
    parameter int TICKET_OFFSET = 2,
    parameter int TICKET_SIZE   = 2,
    localparam int REMW = $clog2(DATA_WIDTH / 8)
) (
    input  logic                             CLK,
    input  logic                             RESET,

    input  logic [DATA_WIDTH-1:0]            RX_DATA,
    input  logic [REMW-1:0]                  RX_REM,
    input  logic                             RX_SOF_N,
    input  logic                             RX_EOF_N,
    input  logic                             RX_SOP_N,
    input  logic                             RX_EOP_N,
    input  logic                             RX_SRC_RDY_N,
    output logic                             RX_DST_RDY_N,

    output logic [OUTPUT_COUNT*DATA_WIDTH-1:0] TX_DATA,
    output logic [OUTPUT_COUNT*REMW-1:0]     TX_REM,
    output logic [OUTPUT_COUNT-1:0]          TX_SOF_N,
    output logic [OUTPUT_COUNT-1:0]          TX_EOF_N,
    output logic [OUTPUT_COUNT-1:0]          TX_SOP_N,
    output logic [OUTPUT_COUNT-1:0]          TX_EOP_N,
    output logic [OUTPUT_COUNT-1:0]          TX_SRC_RDY_N,
    input  logic [OUTPUT_COUNT-1:0]          TX_DST_RDY_N
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int W     = TICKET_OFFSET / BYTES;
    localparam int L     = TICKET_OFFSET % BYTES;
    localparam int SELW  = $clog2(OUTPUT_COUNT);
    localparam int TW    = TICKET_SIZE * 8;
    localparam int PCW   = $clog2(PARTS + 1);
    localparam int WCW   = $clog2(W + 2);

    localparam logic [PCW-1:0]  T_PART   = PCW'(TICKET_PART);
    localparam logic [PCW-1:0]  P_MAX    = PCW'(PARTS);
    localparam logic [WCW-1:0]  T_WORD   = WCW'(W);
    localparam logic [WCW-1:0]  W_MAX    = WCW'(W + 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(OUTPUT_COUNT - 1);

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    state_t          state;
    logic [SELW-1:0] in_sel;
    logic [TW-1:0]   ticket;
    logic [PCW-1:0]  part_cnt;
    logic [WCW-1:0]  word_cnt;

    logic                  valid;
    logic [SELW-1:0]       r_dest;
    logic [DATA_WIDTH-1:0] r_data;
    logic [REMW-1:0]       r_rem;
    logic                  r_sof_n;
    logic                  r_eof_n;
    logic                  r_sop_n;
    logic                  r_eop_n;

    logic                  drain;
    logic                  rx_rdy;
    logic                  rx_xfer;
    logic [PCW-1:0]        cur_part;
    logic [WCW-1:0]        cur_word;
    logic                  hit;
    logic [DATA_WIDTH-1:0] mod_data;

    // SOF/SOP restart the position counters for the word being presented
    always_comb begin
        cur_part = RX_SOF_N ? part_cnt : '0;
        cur_word = RX_SOP_N ? word_cnt : '0;
        hit      = (cur_part == T_PART) && (cur_word == T_WORD);
        mod_data = RX_DATA;
        if (hit) begin
            for (int b = 0; b < TICKET_SIZE; b++) begin
                mod_data[(L + b) * 8 +: 8] = ticket[b * 8 +: 8];
            end
        end
    end

    assign drain        = valid && !TX_DST_RDY_N[r_dest];
    assign rx_rdy       = !RESET && (!valid || drain);
    assign RX_DST_RDY_N = !rx_rdy;
    assign rx_xfer      = rx_rdy && !RX_SRC_RDY_N;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            in_sel   <= '0;
            ticket   <= '0;
            part_cnt <= '0;
            word_cnt <= '0;
        end else if (rx_xfer) begin
            if (!RX_EOF_N) begin
                in_sel <= (in_sel == SEL_LAST) ? '0 : in_sel + 1'b1;
                ticket <= ticket + 1'b1;
            end
            unique case (state)
                IDLE:
                    if (!RX_SOF_N && RX_EOF_N) state <= IN_FRAME;
                IN_FRAME:
                    if (!RX_EOF_N) state <= IDLE;
                default:
                    state <= IDLE;
            endcase
            // counters saturate; only positions up to the ticket matter
            if (!RX_EOP_N) begin
                part_cnt <= (cur_part == P_MAX) ? P_MAX : cur_part + 1'b1;
            end else begin
                part_cnt <= cur_part;
            end
            word_cnt <= (cur_word == W_MAX) ? W_MAX : cur_word + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid   <= 1'b0;
            r_dest  <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_sof_n <= 1'b1;
            r_eof_n <= 1'b1;
            r_sop_n <= 1'b1;
            r_eop_n <= 1'b1;
        end else if (rx_xfer) begin
            valid   <= 1'b1;
            r_dest  <= in_sel;
            r_data  <= mod_data;
            r_rem   <= RX_REM;
            r_sof_n <= RX_SOF_N;
            r_eof_n <= RX_EOF_N;
            r_sop_n <= RX_SOP_N;
            r_eop_n <= RX_EOP_N;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    always_comb begin
        TX_SRC_RDY_N = '1;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            TX_SRC_RDY_N[i] = !(valid && (r_dest == SELW'(i)));
        end
    end

    assign TX_DATA  = {OUTPUT_COUNT{r_data}};
    assign TX_REM   = {OUTPUT_COUNT{r_rem}};
    assign TX_SOF_N = {OUTPUT_COUNT{r_sof_n}};
    assign TX_EOF_N = {OUTPUT_COUNT{r_eof_n}};
    assign TX_SOP_N = {OUTPUT_COUNT{r_sop_n}};
    assign TX_EOP_N = {OUTPUT_COUNT{r_eop_n}};

endmodule

// File: tb/tb_fl_ticket_distributor.sv
// Bench for fl_ticket_distributor: random and directed frames checked
// against a frame-level scoreboard built from round-robin/ticket rules.
module tb_fl_ticket_distributor;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] RX_DATA;
    logic [0:0]  RX_REM;
    logic        RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N;
    logic        RX_SRC_RDY_N;
    logic        RX_DST_RDY_N;
    logic [63:0] TX_DATA;
    logic [3:0]  TX_REM;
    logic [3:0]  TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
    logic [3:0]  TX_SRC_RDY_N;
    logic [3:0]  TX_DST_RDY_N;

    fl_ticket_distributor #(
        .DATA_WIDTH(16), .OUTPUT_COUNT(4), .PARTS(3),
        .TICKET_PART(0), .TICKET_OFFSET(2), .TICKET_SIZE(2)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_REM(RX_REM),
        .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N),
        .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N),
        .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
        .TX_DATA(TX_DATA), .TX_REM(TX_REM),
        .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
        .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N),
        .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          lane;
        logic [20:0] w;
    } exp_t;

    exp_t        exp_q[$];
    int          sof_seq[$];
    int unsigned cyc = 0;
    int unsigned sof_cyc[4];
    int unsigned eof_cyc[4];
    int          n_chk = 0;
    int          n_pass = 0;
    int          frame_no = 0;
    int          tx_mode = 0;
    logic [3:0]  force_dst = '0;
    bit          gaps_on = 0;
    logic [20:0] mon_got;
    int          mon_idx;
    int          t3_wait;
    int unsigned t_start;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    endtask

    initial begin
        TX_DST_RDY_N = 4'hF;
        forever begin
            @(posedge CLK);
            #1;
            case (tx_mode)
                0:       TX_DST_RDY_N = 4'h0;
                1:       TX_DST_RDY_N = 4'($urandom);
                default: TX_DST_RDY_N = force_dst;
            endcase
        end
    end

    // scoreboard: per-output FIFO order of expected words
    always @(negedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (!TX_SRC_RDY_N[i] && !TX_DST_RDY_N[i]) begin
                mon_got = {TX_SOF_N[i], TX_EOF_N[i], TX_SOP_N[i],
                           TX_EOP_N[i], TX_REM[i], TX_DATA[i*16 +: 16]};
                chk("tx_onehot", $countones(~TX_SRC_RDY_N), 1);
                mon_idx = -1;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (exp_q[k].lane == i) begin
                        mon_idx = k;
                        break;
                    end
                end
                if (mon_idx < 0) begin
                    chk("tx_extra", mon_idx, 0);
                end else begin
                    chk("tx_word", mon_got, exp_q[mon_idx].w);
                    exp_q.delete(mon_idx);
                end
                if (!TX_SOF_N[i]) begin
                    sof_seq.push_back(i);
                    sof_cyc[i] = cyc;
                end
                if (!TX_EOF_N[i]) eof_cyc[i] = cyc;
            end
        end
    end

    task automatic send_word(input logic [15:0] d, input logic r,
                             input logic sof_n, input logic eof_n,
                             input logic sop_n, input logic eop_n);
        int t;
        if (gaps_on) begin
            while ($urandom_range(3) == 0) begin
                RX_SRC_RDY_N = 1'b1;
                @(posedge CLK);
                #1;
            end
        end
        RX_DATA = d;
        RX_REM = r;
        RX_SOF_N = sof_n;
        RX_EOF_N = eof_n;
        RX_SOP_N = sop_n;
        RX_EOP_N = eop_n;
        RX_SRC_RDY_N = 1'b0;
        t = 0;
        forever begin
            @(negedge CLK);
            if (!RX_DST_RDY_N) break;
            t++;
            if (t > 300) begin
                chk("rx_timeout", t, 0);
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $fatal(1, "rx handshake stuck");
            end
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        RX_SRC_RDY_N = 1'b1;
    endtask

    // model: frame n goes to output n%4 and carries ticket n mod 2^16
    // in word 1 of part 0 (whole 16-bit word here)
    task automatic send_frame(input int np, input int l0, input int l1,
                              input int l2, input int abort_at);
        int          lens[3];
        int          lane;
        int          sent;
        logic [15:0] tk;
        logic [15:0] d;
        logic [15:0] ed;
        logic        r, sof_n, eof_n, sop_n, eop_n;
        lens = '{l0, l1, l2};
        lane = frame_no % 4;
        tk = 16'(frame_no);
        sent = 0;
        for (int p = 0; p < np; p++) begin
            for (int w = 0; w < lens[p]; w++) begin
                if (abort_at >= 0 && sent == abort_at) return;
                d = 16'($urandom);
                sof_n = !(p == 0 && w == 0);
                sop_n = !(w == 0);
                eop_n = !(w == lens[p] - 1);
                eof_n = !(!eop_n && p == np - 1);
                r = eop_n ? 1'b1 : 1'($urandom);
                ed = (p == 0 && w == 1) ? tk : d;
                exp_q.push_back('{lane, {sof_n, eof_n, sop_n, eop_n, r, ed}});
                send_word(d, r, sof_n, eof_n, sop_n, eop_n);
                sent++;
            end
        end
        frame_no++;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        RX_SRC_RDY_N = 1'b1;
        @(negedge CLK);
        chk("rst_rx_rdy", RX_DST_RDY_N, 1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        frame_no = 0;
        @(negedge CLK);
        chk("rst_src_rdy", TX_SRC_RDY_N, 4'hF);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        RX_DATA = '0;
        RX_REM = '0;
        RX_SOF_N = 1'b1;
        RX_EOF_N = 1'b1;
        RX_SOP_N = 1'b1;
        RX_EOP_N = 1'b1;
        RX_SRC_RDY_N = 1'b1;
        idle(3);
        @(negedge CLK);
        chk("rst_rx_rdy_n", RX_DST_RDY_N, 1);
        chk("rst_tx_src", TX_SRC_RDY_N, 4'hF);
        chk("rst_tx_data", TX_DATA[31:0], 0);
        chk("rst_tx_rem", TX_REM, 0);
        chk("rst_tx_sof", TX_SOF_N, 4'hF);
        chk("rst_tx_eop", TX_EOP_N, 4'hF);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_rdy", RX_DST_RDY_N, 0);
        @(posedge CLK);
        #1;

        // eight 3-part frames, all outputs ready
        sof_seq.delete();
        for (int f = 0; f < 8; f++) begin
            send_frame(3, 2 + $urandom_range(2), 1 + $urandom_range(3),
                       1 + $urandom_range(2), -1);
        end
        idle(3);
        chk("t1_count", sof_seq.size(), 8);
        for (int k = 0; k < 8 && k < sof_seq.size(); k++) begin
            chk("t1_lane", sof_seq[k], k % 4);
        end

        // back-to-back single-word frames
        t_start = cyc;
        for (int f = 0; f < 8; f++) send_frame(1, 1, 0, 0, -1);
        chk("t2_tput", cyc - t_start, 8);
        idle(3);
        chk("t2_b2b", sof_cyc[1] - eof_cyc[0], 1);

        // output 1 stalled while frame 1 is in flight
        force_dst = 4'b0010;
        tx_mode = 2;
        fork
            begin
                send_frame(3, 2, 3, 2, -1);
                send_frame(3, 3, 4, 2, -1);
                send_frame(1, 2, 0, 0, -1);
            end
            begin
                t3_wait = 0;
                @(negedge CLK);
                while (TX_SRC_RDY_N[1] && t3_wait < 300) begin
                    @(negedge CLK);
                    t3_wait++;
                end
                chk("t3_reach", TX_SRC_RDY_N[1], 0);
                for (int k = 0; k < 10; k++) begin
                    chk("t3_rx_stall", RX_DST_RDY_N, 1);
                    chk("t3_out2_idle", TX_SRC_RDY_N[2], 1);
                    @(negedge CLK);
                end
                force_dst = 4'b0000;
            end
        join
        tx_mode = 0;
        idle(3);
        chk("t3_drain", exp_q.size(), 0);

        // short part 0 and short frames still consume tickets
        send_frame(3, 2, 2, 2, -1);
        send_frame(3, 1, 3, 2, -1);
        send_frame(3, 2, 1, 1, -1);
        send_frame(1, 1, 0, 0, -1);
        send_frame(2, 3, 1, 0, -1);

        // random traffic with random backpressure and RX gaps
        tx_mode = 1;
        gaps_on = 1;
        for (int f = 0; f < 60; f++) begin
            send_frame(1 + $urandom_range(2), 1 + $urandom_range(3),
                       1 + $urandom_range(3), 1 + $urandom_range(3), -1);
        end
        tx_mode = 0;
        gaps_on = 0;
        idle(5);
        chk("rand_drain", exp_q.size(), 0);

        // reset in the middle of a frame headed for output 2
        do_reset();
        send_frame(3, 2, 2, 2, -1);
        send_frame(3, 2, 2, 2, -1);
        send_frame(3, 3, 2, 2, 2);
        do_reset();
        sof_seq.delete();
        send_frame(3, 2, 2, 2, -1);
        idle(3);
        chk("t6_sof_cnt", sof_seq.size(), 1);
        if (sof_seq.size() > 0) chk("t6_lane", sof_seq[0], 0);
        chk("t6_drain", exp_q.size(), 0);

        // ticket wrap: 65534 filler frames, then FFFE, FFFF, 0000
        do_reset();
        for (int f = 0; f < 65534; f++) send_frame(1, 1, 0, 0, -1);
        send_frame(3, 2, 2, 2, -1);
        send_frame(3, 2, 1, 1, -1);
        send_frame(3, 3, 2, 1, -1);
        idle(5);
        chk("final_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
